// File: rtl/sign_extend.sv
// Widens an N-bit immediate to the 16-bit datapath word: sign, zero and x2 branch-offset forms, plus a registered select.
// Latency: combinational outputs 0 cycles; out_q/out_valid 1 cycle after a load edge.
// Backpressure: none; load is a plain capture enable and sel=11 holds like load=0.
module sign_extend #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic [1:0]   sel,
    input  logic         load,
    output logic [15:0]  out,
    output logic [15:0]  out_zext,
    output logic [15:0]  out_sh1,
    output logic [15:0]  out_q,
    output logic         out_valid
);

    localparam logic [1:0] SEL_SEXT = 2'b00;
    localparam logic [1:0] SEL_ZEXT = 2'b01;
    localparam logic [1:0] SEL_SH1  = 2'b10;

    generate
        if (N < 1 || N > 16) begin : g_bad_width
            $error("sign_extend: N must be in 1..16");
        end
    endgenerate

    // A zero-width replication is not legal, so full width is its own case.
    generate
        if (N == 16) begin : g_full
            assign out      = in;
            assign out_zext = in;
        end else begin : g_widen
            assign out      = {{(16-N){in[N-1]}}, in};
            assign out_zext = {{(16-N){1'b0}}, in};
        end
    endgenerate

    assign out_sh1 = {out[14:0], 1'b0};

    logic [15:0] out_q_d;
    logic        valid_q;
    logic        valid_d;

    always_comb begin
        out_q_d = out_q;
        valid_d = valid_q;
        if (load) begin
            case (sel)
                SEL_SEXT: begin out_q_d = out;      valid_d = 1'b1; end
                SEL_ZEXT: begin out_q_d = out_zext; valid_d = 1'b1; end
                SEL_SH1:  begin out_q_d = out_sh1;  valid_d = 1'b1; end
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_q_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;

endmodule

// File: tb/tb_sign_extend.sv
// Directed checks of sign_extend: combinational widths/boundaries and the registered select path.
module tb_sign_extend;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Control inputs of the combinational-only instances are left X.
    logic       fl_clk, fl_rst, fl_load;
    logic [1:0] fl_sel;

    logic [7:0]  in8;
    logic [0:0]  in1;
    logic [15:0] in16;
    logic [3:0]  in4;
    logic [15:0] o8, z8, s8, q8;   logic v8;
    logic [15:0] o1, z1, s1, q1;   logic v1;
    logic [15:0] o16, z16, s16, q16; logic v16;
    logic [15:0] o4, z4, s4, q4;   logic v4;

    sign_extend #(.N(8)) u_f8 (.clk(fl_clk), .rst(fl_rst), .in(in8), .sel(fl_sel), .load(fl_load),
        .out(o8), .out_zext(z8), .out_sh1(s8), .out_q(q8), .out_valid(v8));
    sign_extend #(.N(1)) u_f1 (.clk(fl_clk), .rst(fl_rst), .in(in1), .sel(fl_sel), .load(fl_load),
        .out(o1), .out_zext(z1), .out_sh1(s1), .out_q(q1), .out_valid(v1));
    sign_extend #(.N(16)) u_f16 (.clk(fl_clk), .rst(fl_rst), .in(in16), .sel(fl_sel), .load(fl_load),
        .out(o16), .out_zext(z16), .out_sh1(s16), .out_q(q16), .out_valid(v16));
    sign_extend #(.N(4)) u_f4 (.clk(fl_clk), .rst(fl_rst), .in(in4), .sel(fl_sel), .load(fl_load),
        .out(o4), .out_zext(z4), .out_sh1(s4), .out_q(q4), .out_valid(v4));

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  r_in;
    logic [1:0]  r_sel;
    logic        r_load;
    logic [15:0] r_out, r_zext, r_sh1, r_q;
    logic        r_valid;

    sign_extend #(.N(8)) u_reg (.clk(clk), .rst(rst), .in(r_in), .sel(r_sel), .load(r_load),
        .out(r_out), .out_zext(r_zext), .out_sh1(r_sh1), .out_q(r_q), .out_valid(r_valid));

    always #5 clk = ~clk;

    logic [7:0]  sweep_in  [11] = '{8'h00, 8'h19, 8'h32, 8'h4B, 8'h64, 8'h7D, 8'h96, 8'hAF, 8'hC8, 8'hE1, 8'hFA};
    logic [15:0] sweep_exp [11] = '{16'h0000, 16'h0019, 16'h0032, 16'h004B, 16'h0064, 16'h007D,
                                    16'hFF96, 16'hFFAF, 16'hFFC8, 16'hFFE1, 16'hFFFA};

    task automatic cycle_load(input logic [1:0] s, input logic l);
        @(negedge clk);
        r_sel  = s;
        r_load = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        fl_clk = 1'bx; fl_rst = 1'bx; fl_load = 1'bx; fl_sel = 2'bxx;
        in8 = '0; in1 = '0; in16 = '0; in4 = '0;
        rst = 1'b0; r_in = 8'h00; r_sel = 2'b00; r_load = 1'b1;

        // Combinational sweep, N=8
        for (int i = 0; i < 11; i++) begin
            in8 = sweep_in[i];
            #3;
            check($sformatf("sweep_%02h", sweep_in[i]), o8, sweep_exp[i]);
            #7;
        end

        in8 = 8'h7F; #3;
        check("7F_out", o8, 16'h007F); check("7F_zext", z8, 16'h007F); check("7F_sh1", s8, 16'h00FE);
        in8 = 8'h80; #3;
        check("80_out", o8, 16'hFF80); check("80_zext", z8, 16'h0080); check("80_sh1", s8, 16'hFF00);
        in8 = 8'hFF; #3;
        check("FF_out", o8, 16'hFFFF); check("FF_sh1", s8, 16'hFFFE);

        in1 = 1'b1; #3; check("n1_in1", o1, 16'hFFFF);
        in1 = 1'b0; #3; check("n1_in0", o1, 16'h0000);
        in16 = 16'h8001; #3;
        check("n16_out", o16, 16'h8001); check("n16_sh1", s16, 16'h0002);
        in4 = 4'h9; #3;
        check("n4_out", o4, 16'hFFF9); check("n4_zext", z4, 16'h0009);

        // Registered path: reset state, and held reset ignores load
        #1;
        check("rst_q", r_q, 16'h0000); check("rst_valid", {15'b0, r_valid}, 16'h0000);
        @(posedge clk); #1;
        check("rst_hold_q", r_q, 16'h0000); check("rst_hold_valid", {15'b0, r_valid}, 16'h0000);

        @(negedge clk);
        rst = 1'b1; r_in = 8'h96;
        cycle_load(2'b00, 1'b1);
        check("ld_sext", r_q, 16'hFF96); check("ld_valid", {15'b0, r_valid}, 16'h0001);
        cycle_load(2'b01, 1'b1); check("ld_zext", r_q, 16'h0096);
        cycle_load(2'b10, 1'b1); check("ld_sh1", r_q, 16'hFF2C);
        cycle_load(2'b11, 1'b1); check("hold_sel11", r_q, 16'hFF2C);
        cycle_load(2'b00, 1'b0); check("hold_load0", r_q, 16'hFF2C);

        // Input change between edges reaches only the combinational path
        r_in = 8'h05; #1;
        check("mid_in_out", r_out, 16'h0005); check("mid_in_q", r_q, 16'hFF2C);
        r_in = 8'h96;
        cycle_load(2'b00, 1'b1); check("reload_sext", r_q, 16'hFF96);

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        check("arst_q", r_q, 16'h0000); check("arst_valid", {15'b0, r_valid}, 16'h0000);
        check("arst_out", r_out, 16'hFF96);

        // First capture after release
        @(negedge clk);
        rst = 1'b1;
        cycle_load(2'b01, 1'b1);
        check("post_rel_q", r_q, 16'h0096); check("post_rel_valid", {15'b0, r_valid}, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
